// File: rtl/nextasic_pkg.sv
// Shared nextasic definitions: handshake-reader state encoding and FIFO sizing helper.
package nextasic_pkg;

  typedef enum logic [0:0] {
    DSR_IDLE = 1'b0,
    DSR_ACK  = 1'b1
  } dsr_state_e;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is visible on dout whenever not empty.
module sync_fifo
  import nextasic_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [W-1:0]                  din,
  output logic [W-1:0]                  dout,
  output logic                          empty,
  output logic                          full,
  output logic [level_w(DEPTH)-1:0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_wr_en;
  logic          w_rd_en;

  assign full    = (r_level == LW'(DEPTH));
  assign empty   = (r_level == '0);
  // Full is judged on the pre-edge level, so a same-cycle pop never frees room for a push.
  assign w_wr_en = push & ~full;
  assign w_rd_en = pop & ~empty;
  assign dout    = r_mem[r_rd_ptr];
  assign level   = r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/data_sync_reader.sv
// Destination-side consumer of the single-word CDC handshake: captures one word per
// handshake into a FWFT FIFO, acknowledges only with room, and counts captured words.
module data_sync_reader
  import nextasic_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [W-1:0]              sync_data,
  input  logic                      sync_valid,
  output logic                      sync_retrieved,
  output logic [W-1:0]              m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [level_w(DEPTH)-1:0] level,
  output logic [CNT_W-1:0]          words_rx
);

  dsr_state_e       r_state;
  dsr_state_e       w_state_nxt;
  logic             r_retrieved;
  logic             w_retrieved_nxt;
  logic             w_push;
  logic             w_empty;
  logic             w_full;
  logic [CNT_W-1:0] r_words_rx;

  sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (m_ready),
    .din   (sync_data),
    .dout  (m_data),
    .empty (w_empty),
    .full  (w_full),
    .level (level)
  );

  // Acknowledge only from IDLE with room; ACK holds until the source withdraws valid.
  always_comb begin
    w_state_nxt     = r_state;
    w_retrieved_nxt = 1'b0;
    w_push          = 1'b0;
    case (r_state)
      DSR_IDLE: begin
        if (sync_valid && !w_full) begin
          w_push          = 1'b1;
          w_retrieved_nxt = 1'b1;
          w_state_nxt     = DSR_ACK;
        end
      end
      DSR_ACK: begin
        if (sync_valid) w_retrieved_nxt = 1'b1;
        else            w_state_nxt     = DSR_IDLE;
      end
      default: w_state_nxt = DSR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= DSR_IDLE;
      r_retrieved <= 1'b0;
      r_words_rx  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_retrieved <= w_retrieved_nxt;
      r_words_rx  <= r_words_rx + CNT_W'(w_push);
    end
  end

  assign sync_retrieved = r_retrieved;
  assign m_valid        = ~w_empty;
  assign words_rx       = r_words_rx;

endmodule

// File: tb/tb_data_sync_reader.sv
// Bench for data_sync_reader: directed vector table, hand sequences, and a randomized
// source/sink run checked against an occupancy/ordering reference model.
module tb_data_sync_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sync_data;
  logic        sync_valid;
  logic        m_ready;
  logic        sync_retrieved;
  logic [3:0]  m_data;
  logic        m_valid;
  logic [2:0]  level;
  logic [15:0] words_rx;
  logic        ret4;
  logic [3:0]  m_data4;
  logic        m_valid4;
  logic [2:0]  level4;
  logic [3:0]  words_rx4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_sync_reader #(.W(4), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sync_data(sync_data), .sync_valid(sync_valid),
    .sync_retrieved(sync_retrieved), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .level(level), .words_rx(words_rx)
  );

  data_sync_reader #(.W(4), .DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sync_data(sync_data), .sync_valid(sync_valid),
    .sync_retrieved(ret4), .m_data(m_data4), .m_valid(m_valid4),
    .m_ready(m_ready), .level(level4), .words_rx(words_rx4)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ret"},   sync_retrieved, 0);
    chk({tag, "_mv"},    m_valid, 0);
    chk({tag, "_lvl"},   level, 0);
    chk({tag, "_wrx"},   words_rx, 0);
    chk({tag, "_wrx4"},  words_rx4, 0);
  endtask

  typedef struct {
    logic       sv;
    logic [3:0] sd;
    logic       mr;
    logic       e_ret;
    logic       e_mv;
    logic [3:0] e_md;
    int         e_lvl;
    int         e_wrx;
  } vec_t;

  vec_t tbl[21];

  // Reference model state for the random run
  logic [3:0] exp_q[$];
  int consumed, popped, sent, cyc;
  bit pop_pend, done;
  localparam int NWORDS = 40;

  initial begin
    // Single word, acknowledge release, backpressure, full-plus-pop, drain.
    tbl[0]  = '{1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 4'h1, 1, 1};
    tbl[1]  = '{1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 4'h0, 0, 1};
    tbl[2]  = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 4'h2, 1, 2};
    tbl[3]  = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 4'h2, 1, 2};
    tbl[4]  = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 4'h2, 1, 2};
    tbl[5]  = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 4'h2, 1, 2};
    tbl[6]  = '{1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 4'h2, 1, 2};
    tbl[7]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 4'h2, 2, 3};
    tbl[8]  = '{1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 4'h2, 2, 3};
    tbl[9]  = '{1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 4'h2, 3, 4};
    tbl[10] = '{1'b0, 4'h4, 1'b0, 1'b0, 1'b1, 4'h2, 3, 4};
    tbl[11] = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 4'h2, 4, 5};
    tbl[12] = '{1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 4'h2, 4, 5};
    tbl[13] = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 4'h2, 4, 5};
    tbl[14] = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 4'h2, 4, 5};
    tbl[15] = '{1'b1, 4'h6, 1'b1, 1'b0, 1'b1, 4'h3, 3, 5};
    tbl[16] = '{1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 4'h3, 4, 6};
    tbl[17] = '{1'b0, 4'h6, 1'b1, 1'b0, 1'b1, 4'h4, 3, 6};
    tbl[18] = '{1'b0, 4'h6, 1'b1, 1'b0, 1'b1, 4'h5, 2, 6};
    tbl[19] = '{1'b0, 4'h6, 1'b1, 1'b0, 1'b1, 4'h6, 1, 6};
    tbl[20] = '{1'b0, 4'h6, 1'b1, 1'b0, 1'b0, 4'h0, 0, 6};

    rst_n = 1'b0; sync_valid = 1'b0; sync_data = 4'h0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      sync_valid = tbl[i].sv; sync_data = tbl[i].sd; m_ready = tbl[i].mr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ret", i),  sync_retrieved, tbl[i].e_ret);
      chk($sformatf("v%0d_mv", i),   m_valid, tbl[i].e_mv);
      if (tbl[i].e_mv) chk($sformatf("v%0d_md", i), m_data, tbl[i].e_md);
      chk($sformatf("v%0d_lvl", i),  level, tbl[i].e_lvl);
      chk($sformatf("v%0d_wrx", i),  words_rx, tbl[i].e_wrx);
      chk($sformatf("v%0d_wrx4", i), words_rx4, tbl[i].e_wrx % 16);
      @(negedge clk);
    end

    // Reset while in ACK with two words buffered; pending word recaptured exactly once.
    m_ready = 1'b0; sync_valid = 1'b1; sync_data = 4'h7;
    @(negedge clk) sync_valid = 1'b0;
    @(negedge clk) begin sync_valid = 1'b1; sync_data = 4'h8; end
    @(posedge clk);
    #1 chk("pre_rst_lvl", level, 2);
    chk("pre_rst_ret", sync_retrieved, 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk) begin rst_n = 1'b1; sync_data = 4'h9; end
    @(posedge clk);
    #1 chk("post_rst_ret", sync_retrieved, 1);
    chk("post_rst_wrx", words_rx, 1);
    chk("post_rst_lvl", level, 1);
    chk("post_rst_md", m_data, 9);
    @(negedge clk) sync_valid = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_release", sync_retrieved, 0);
    chk("post_rst_wrx_once", words_rx, 1);

    // Random run: source model behaves like the sync block (updates on falling edge).
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    consumed = 0; popped = 0; sent = 0; pop_pend = 1'b0; done = 1'b0;
    for (cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (pop_pend) begin
        popped++;
        void'(exp_q.pop_front());
      end
      if (sync_retrieved) begin
        chk("ack_only_with_valid", sync_valid, 1);
        if (sync_valid) begin
          consumed++;
          exp_q.push_back(sync_data);
          sync_valid = 1'b0;
        end
      end
      chk("rnd_lvl", level, consumed - popped);
      chk("rnd_mv", m_valid, (exp_q.size() != 0) ? 1 : 0);
      chk("rnd_wrx", words_rx, consumed & 16'hFFFF);
      chk("rnd_wrx4", words_rx4, consumed % 16);
      if (!sync_valid && !sync_retrieved && sent < NWORDS && ($urandom % 4) != 0) begin
        sync_data = 4'($urandom);
        sync_valid = 1'b1;
        sent++;
      end
      m_ready = (cyc < 60) ? (($urandom % 5) == 0) : (($urandom % 3) != 0);
      pop_pend = m_valid && m_ready;
      if (pop_pend && exp_q.size() != 0) chk("rnd_md", m_data, exp_q[0]);
      done = (sent == NWORDS) && !sync_valid && !sync_retrieved &&
             (consumed == NWORDS) && (exp_q.size() == 0) && !pop_pend;
    end
    if (!done) chk("rnd_drain_timeout", 0, 1);
    chk("rnd_total", consumed, NWORDS);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
